// File: rtl/zapper_field_if.sv
// Player/obstacle bus between the game front end and the zapper field engine.
// Carries the start request and player y in, obstacle position, score and game state out.
// The engine side takes the slave modport; the player/renderer side takes master.
interface zapper_field_if;
  logic        start;
  logic [8:0]  y0;
  logic [1:0]  game_state;
  logic [9:0]  zap_x;
  logic [8:0]  zap_y;
  logic [15:0] score;
  logic        hit;

  modport master (
    output start, y0,
    input  game_state, zap_x, zap_y, score, hit
  );

  modport slave (
    input  start, y0,
    output game_state, zap_x, zap_y, score, hit
  );
endinterface

// File: rtl/zapper_field.sv
// Scrolls one zapper right-to-left, detects overlap with the player box, keeps score.
// Latency: every output is registered; input changes take effect on the next clock edge.
// Backpressure: none. start is a level request and y0 is sampled every cycle.
module zapper_field #(
  parameter int TICK_W   = 8,
  parameter int SCREEN_W = 640,
  parameter int BARRY_X  = 100,
  parameter int BARRY_W  = 32,
  parameter int BARRY_H  = 48,
  parameter int ZAP_W    = 16,
  parameter int ZAP_H    = 96,
  parameter int ZAP_Y0   = 200
) (
  input  logic            clk,
  input  logic            reset,
  zapper_field_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam logic [9:0]  SPAWN_X    = 10'(SCREEN_W);
  localparam logic [8:0]  START_Y    = 9'(ZAP_Y0);
  localparam logic [7:0]  LFSR_SEED  = 8'hA5;
  // Collision arithmetic runs at 11 bits so that no box edge sum can wrap.
  localparam logic [10:0] BOX_LEFT   = 11'(BARRY_X);
  localparam logic [10:0] BOX_RIGHT  = 11'(BARRY_X + BARRY_W);
  localparam logic [10:0] BOX_HEIGHT = 11'(BARRY_H);
  localparam logic [10:0] ZAP_WIDTH  = 11'(ZAP_W);
  localparam logic [10:0] ZAP_HEIGHT = 11'(ZAP_H);

  state_t              state_r, state_nxt;
  logic [9:0]          zap_x_r, zap_x_nxt;
  logic [8:0]          zap_y_r, zap_y_nxt;
  logic [15:0]         score_r, score_nxt;
  logic                hit_r, hit_nxt;
  logic [TICK_W-1:0]   tick_r, tick_nxt;
  logic [7:0]          lfsr_r, lfsr_nxt;

  logic [10:0]         zx, zy, py;
  logic                collide;
  logic [7:0]          lfsr_step;

  // Strict box overlap on the registered zapper position and the live player y.
  always_comb begin
    zx = {1'b0, zap_x_r};
    zy = {2'b00, zap_y_r};
    py = {2'b00, bus.y0};
    collide = (zx < BOX_RIGHT) && ((zx + ZAP_WIDTH) > BOX_LEFT) &&
              (zy < (py + BOX_HEIGHT)) && ((zy + ZAP_HEIGHT) > py);
    lfsr_step = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  end

  // Next-state and next-output logic; everything holds unless a branch changes it.
  always_comb begin
    state_nxt = state_r;
    zap_x_nxt = zap_x_r;
    zap_y_nxt = zap_y_r;
    score_nxt = score_r;
    hit_nxt   = 1'b0;
    tick_nxt  = tick_r;
    lfsr_nxt  = lfsr_r;
    case (state_r)
      IDLE, OVER: begin
        // A new round restarts scroll and score but keeps the zapper height and LFSR.
        if (bus.start) begin
          state_nxt = PLAY;
          zap_x_nxt = SPAWN_X;
          score_nxt = 16'd0;
          tick_nxt  = '0;
        end
      end
      PLAY: begin
        if (collide) begin
          // Freeze the field exactly where the hit happened.
          state_nxt = OVER;
          hit_nxt   = 1'b1;
        end else if (&tick_r) begin
          tick_nxt = '0;
          if (zap_x_r == 10'd0) begin
            zap_x_nxt = SPAWN_X;
            lfsr_nxt  = lfsr_step;
            zap_y_nxt = 9'd64 + {1'b0, lfsr_step};
            score_nxt = (score_r == 16'hFFFF) ? score_r : score_r + 16'd1;
          end else begin
            zap_x_nxt = zap_x_r - 10'd1;
          end
        end else begin
          tick_nxt = tick_r + TICK_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register with synchronous reset back to the power-on field.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      zap_x_r <= SPAWN_X;
      zap_y_r <= START_Y;
      score_r <= 16'd0;
      hit_r   <= 1'b0;
      tick_r  <= '0;
      lfsr_r  <= LFSR_SEED;
    end else begin
      state_r <= state_nxt;
      zap_x_r <= zap_x_nxt;
      zap_y_r <= zap_y_nxt;
      score_r <= score_nxt;
      hit_r   <= hit_nxt;
      tick_r  <= tick_nxt;
      lfsr_r  <= lfsr_nxt;
    end
  end

  assign bus.game_state = state_r;
  assign bus.zap_x      = zap_x_r;
  assign bus.zap_y      = zap_y_r;
  assign bus.score      = score_r;
  assign bus.hit        = hit_r;

endmodule

// File: tb/tb_zapper_field.sv
// Bench for zapper_field with a fast scroll tick (one step every 4 cycles).
// Expected outputs come from a behavioural game model, queued as stimulus is driven.
// Scenario constants (positions, LFSR heights, score) are also checked directly.
module tb_zapper_field;

  localparam int TW = 2;
  localparam int TICK_MAX = (1 << TW) - 1;
  localparam int PASS_CYCLES = 641 * (1 << TW);

  typedef struct {
    int gs;
    int x;
    int y;
    int score;
    int hit;
  } exp_t;

  logic clk;
  logic reset;
  zapper_field_if b ();

  zapper_field #(
    .TICK_W   (TW),
    .SCREEN_W (640),
    .BARRY_X  (100),
    .BARRY_W  (32),
    .BARRY_H  (48),
    .ZAP_W    (16),
    .ZAP_H    (96),
    .ZAP_Y0   (200)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  // Behavioural model of the game field.
  int m_gs = 0, m_x = 640, m_y = 200, m_score = 0, m_hit = 0, m_tick = 0, m_lfsr = 'hA5;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, want, want, $time);
  endtask

  task automatic model_step(input logic st, input int yy, input logic rs);
    int fb;
    if (rs) begin
      m_gs = 0; m_x = 640; m_y = 200; m_score = 0; m_hit = 0; m_tick = 0; m_lfsr = 'hA5;
      return;
    end
    m_hit = 0;
    if (m_gs == 1) begin
      if (m_x < 132 && m_x + 16 > 100 && m_y < yy + 48 && m_y + 96 > yy) begin
        m_gs = 2;
        m_hit = 1;
      end else if (m_tick == TICK_MAX) begin
        m_tick = 0;
        if (m_x == 0) begin
          fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
          m_lfsr = ((m_lfsr << 1) & 255) | fb;
          m_y = 64 + m_lfsr;
          m_x = 640;
          if (m_score < 65535) m_score = m_score + 1;
        end else begin
          m_x = m_x - 1;
        end
      end else begin
        m_tick = m_tick + 1;
      end
    end else if (st) begin
      m_gs = 1; m_x = 640; m_score = 0; m_tick = 0;
    end
  endtask

  // One clock: drive inputs, queue the model's expectation, compare after the edge.
  task automatic cyc(input logic st, input logic [8:0] yy, input logic rs);
    exp_t e;
    b.start = st;
    b.y0    = yy;
    reset   = rs;
    model_step(st, int'(yy), rs);
    e.gs = m_gs; e.x = m_x; e.y = m_y; e.score = m_score; e.hit = m_hit;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("game_state", int'(b.game_state), e.gs);
    check("zap_x", int'(b.zap_x), e.x);
    check("zap_y", int'(b.zap_y), e.y);
    check("score", int'(b.score), e.score);
    check("hit", int'(b.hit), e.hit);
  endtask

  task automatic run_until_x(input int target, input int bound, input logic [8:0] yy);
    int n;
    n = 0;
    while (m_x != target && n < bound) begin
      cyc(1'b0, yy, 1'b0);
      n++;
    end
    check("wait_zap_x", int'(b.zap_x), target);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gs"}, int'(b.game_state), 0);
    check({tag, "_x"}, int'(b.zap_x), 640);
    check({tag, "_y"}, int'(b.zap_y), 200);
    check({tag, "_score"}, int'(b.score), 0);
    check({tag, "_hit"}, int'(b.hit), 0);
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    b.start = 1'b0;
    b.y0 = 9'd419;

    // Reset and idle hold.
    cyc(1'b0, 9'd419, 1'b1);
    cyc(1'b0, 9'd419, 1'b1);
    check_reset_vals("reset");
    repeat (20) cyc(1'b0, 9'd419, 1'b0);
    check_reset_vals("idle_hold");

    // Full pass with the player out of the way.
    cyc(1'b1, 9'd419, 1'b0);
    check("play_entry", int'(b.game_state), 1);
    repeat (3) cyc(1'b0, 9'd419, 1'b0);
    check("x_before_step", int'(b.zap_x), 640);
    cyc(1'b0, 9'd419, 1'b0);
    check("x_first_step", int'(b.zap_x), 639);
    repeat (PASS_CYCLES - 4) cyc(1'b0, 9'd419, 1'b0);
    check("pass_x", int'(b.zap_x), 640);
    check("pass_y", int'(b.zap_y), 138);
    check("pass_score", int'(b.score), 1);
    check("pass_gs", int'(b.game_state), 1);

    // Collision with y overlap.
    cyc(1'b0, 9'd250, 1'b1);
    cyc(1'b1, 9'd250, 1'b0);
    run_until_x(131, 3000, 9'd250);
    check("pre_hit_gs", int'(b.game_state), 1);
    cyc(1'b0, 9'd250, 1'b0);
    check("hit_gs", int'(b.game_state), 2);
    check("hit_pulse", int'(b.hit), 1);
    repeat (50) cyc(1'b0, 9'd250, 1'b0);
    check("over_hit_low", int'(b.hit), 0);
    check("over_x", int'(b.zap_x), 131);
    check("over_score", int'(b.score), 0);
    check("over_gs", int'(b.game_state), 2);

    // Restart from OVER, then edge-touching player passes cleanly.
    cyc(1'b1, 9'd296, 1'b0);
    check("restart_gs", int'(b.game_state), 1);
    check("restart_x", int'(b.zap_x), 640);
    check("restart_score", int'(b.score), 0);
    check("restart_y", int'(b.zap_y), 200);
    repeat (PASS_CYCLES) cyc(1'b0, 9'd296, 1'b0);
    check("touch_gs", int'(b.game_state), 1);
    check("touch_score", int'(b.score), 1);
    check("touch_x", int'(b.zap_x), 640);

    // One pixel deeper does collide.
    cyc(1'b0, 9'd295, 1'b1);
    cyc(1'b1, 9'd295, 1'b0);
    run_until_x(131, 3000, 9'd295);
    cyc(1'b0, 9'd295, 1'b0);
    check("deep_gs", int'(b.game_state), 2);
    check("deep_hit", int'(b.hit), 1);

    // Reset mid-PLAY restores everything, including the LFSR.
    cyc(1'b1, 9'd419, 1'b0);
    run_until_x(300, 2000, 9'd419);
    cyc(1'b0, 9'd419, 1'b1);
    check_reset_vals("mid_reset");
    cyc(1'b1, 9'd419, 1'b0);
    repeat (PASS_CYCLES) cyc(1'b0, 9'd419, 1'b0);
    check("lfsr_reseed_y", int'(b.zap_y), 138);
    check("lfsr_reseed_score", int'(b.score), 1);

    // Score saturation: preload the top value, then one more respawn.
    force dut.score_r = 16'hFFFF;
    m_score = 65535;
    cyc(1'b0, 9'd419, 1'b0);
    release dut.score_r;
    check("sat_preload", int'(b.score), 65535);
    repeat (PASS_CYCLES - 1) cyc(1'b0, 9'd419, 1'b0);
    check("sat_score", int'(b.score), 65535);
    check("sat_x", int'(b.zap_x), 640);
    check("sat_y", int'(b.zap_y), 213);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
